// File: rtl/logic_pipe_pkg.sv
// logic_pipe_pkg
// Shared definitions for the logic_pipe16x bitwise pipeline:
//   op_t        3-bit operation select
//   OP_*        opcode constants (AND .. PASS)
//   MAX_WIDTH   widest operand supported by bitwise_op
//   bitwise_op  applies one opcode to two MAX_WIDTH-bit operands; callers
//               zero-extend narrower operands and keep the low bits.
package logic_pipe_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  localparam int MAX_WIDTH = 64;

  // NOT and PASS look only at in0; in1 is ignored for those two opcodes.
  function automatic logic [MAX_WIDTH-1:0] bitwise_op(
    input op_t                  op,
    input logic [MAX_WIDTH-1:0] in1,
    input logic [MAX_WIDTH-1:0] in0
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = in1 & in0;
      OP_OR:   r = in1 | in0;
      OP_XOR:  r = in1 ^ in0;
      OP_NAND: r = ~(in1 & in0);
      OP_NOR:  r = ~(in1 | in0);
      OP_XNOR: r = ~(in1 ^ in0);
      OP_NOT:  r = ~in0;
      default: r = in0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage
// One elastic valid/ready register stage.
//   clk, reset  clock and synchronous active-high reset
//   in_valid    valid bit offered by the previous stage (or the accept strobe)
//   in_data     payload offered by the previous stage
//   adv_in      advance permission coming back from the next stage
//   adv_out     this stage may load this cycle (next stage advances or we are empty)
//   valid/data  registered contents of this stage
module logic_pipe_stage #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          adv_in,
  output logic          adv_out,
  output logic          valid,
  output logic [DW-1:0] data
);

  // An empty stage can always load, which is what lets bubbles collapse
  // while the output is stalled.
  assign adv_out = adv_in | ~valid;

  // Payload is only captured together with a real transaction, so a bubble
  // passing through leaves the last result (and its flags) untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv_out) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_pipe16x.sv
// logic_pipe16x
// Applies one of eight bitwise operations to two WIDTH-bit operands and
// carries the result plus zero/all-ones flags through STAGES elastic stages.
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (op, in1, in0 sampled on accept)
//   op, in1, in0         operation select and operands
//   out_valid/out_ready  result handshake
//   out, zr, ones        result, result==0, result==all ones
module logic_pipe16x
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ones
);

  localparam int DW = WIDTH + 2;
  localparam logic [MAX_WIDTH-1:0] WMASK = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - WIDTH);

  logic [MAX_WIDTH-1:0] in1_ext;
  logic [MAX_WIDTH-1:0] in0_ext;
  logic [MAX_WIDTH-1:0] res_ext;
  logic [WIDTH-1:0]     res;
  logic                 res_zr;
  logic                 res_ones;
  logic                 accept;
  logic [STAGES-1:0]    v;
  logic [STAGES-1:0]    adv;
  logic [DW-1:0]        d [STAGES];

  // The result is formed at full package width; bits above WIDTH are
  // forced out of the flag tests with WMASK (NOT sets them to one).
  always_comb begin
    in1_ext = '0;
    in0_ext = '0;
    in1_ext[WIDTH-1:0] = in1;
    in0_ext[WIDTH-1:0] = in0;
    res_ext  = bitwise_op(op, in1_ext, in0_ext);
    res      = res_ext[WIDTH-1:0];
    res_zr   = ((res_ext & WMASK) == '0);
    res_ones = ((res_ext | ~WMASK) == {MAX_WIDTH{1'b1}});
  end

  assign in_ready = adv[0] & ~reset;
  assign accept   = in_valid & in_ready;

  // Stage 0 takes the freshly computed result; later stages copy their
  // predecessor. The last stage advances on out_ready, the rest on the
  // advance of the stage in front of them.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          s_valid_in;
    logic [DW-1:0] s_data_in;
    logic          s_adv_in;

    if (i == 0) begin : g_first
      assign s_valid_in = accept;
      assign s_data_in  = {res, res_zr, res_ones};
    end else begin : g_next
      assign s_valid_in = v[i-1];
      assign s_data_in  = d[i-1];
    end

    if (i == STAGES - 1) begin : g_last
      assign s_adv_in = out_ready;
    end else begin : g_mid
      assign s_adv_in = adv[i+1];
    end

    logic_pipe_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (s_valid_in),
      .in_data  (s_data_in),
      .adv_in   (s_adv_in),
      .adv_out  (adv[i]),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  assign out_valid        = v[STAGES-1];
  assign {out, zr, ones}  = d[STAGES-1];

endmodule
